// File: rtl/tff_pkg.sv
// Shared mode encodings and T-chain helpers for the tff_bank family.
package tff_pkg;

   // Mode encodings on the 2-bit mode input.
   localparam logic [1:0] TFF_MODE_TOGGLE = 2'b00;
   localparam logic [1:0] TFF_MODE_UP     = 2'b01;
   localparam logic [1:0] TFF_MODE_DOWN   = 2'b10;
   localparam logic [1:0] TFF_MODE_HOLD   = 2'b11;

   // Helpers work on the widest legal bank; callers truncate to their own width.
   localparam int unsigned TFF_MAX_WIDTH = 32;

   typedef logic [TFF_MAX_WIDTH-1:0] tff_vec_t;

   // Increment toggle vector: bit i toggles when every lower bit is 1 (bit 0 always).
   function automatic tff_vec_t tff_chain_up(input tff_vec_t q);
      tff_vec_t t;
      logic     carry;
      carry = 1'b1;
      for (int i = 0; i < TFF_MAX_WIDTH; i++) begin
         t[i]  = carry;
         carry = carry & q[i];
      end
      return t;
   endfunction

   // Decrement toggle vector: bit i toggles when every lower bit is 0 (bit 0 always).
   function automatic tff_vec_t tff_chain_down(input tff_vec_t q);
      tff_vec_t t;
      logic     borrow;
      borrow = 1'b1;
      for (int i = 0; i < TFF_MAX_WIDTH; i++) begin
         t[i]   = borrow;
         borrow = borrow & ~q[i];
      end
      return t;
   endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with asynchronous active-low reset to a parameterised value and a
// synchronous parallel load that overrides the toggle request.
module tff_cell #(
   parameter logic RESET_BIT = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic t,
   input  logic load,
   input  logic d,
   output logic q,
   output logic qb
);

   logic q_q;

   // State bit: reset, then load, then toggle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= RESET_BIT;
      end else if (load) begin
         q_q <= d;
      end else if (t) begin
         q_q <= ~q_q;
      end
   end

   assign q  = q_q;
   assign qb = ~q_q;

endmodule

// File: rtl/tff_bank.sv
// WIDTH-bit bank of T flip-flops: per-bit toggle, modulo-MOD up/down counting built from
// T-chains, hold, parallel load, terminal-count flag and a registered wrap pulse.
module tff_bank
   import tff_pkg::*;
#(
   parameter int unsigned      WIDTH     = 4,
   parameter longint unsigned  MOD       = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] t,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             tc,
   output logic             wrap
);

   // Largest count value; all ones when MOD is 2**WIDTH, giving natural binary wrap.
   localparam logic [WIDTH-1:0] MOD_M1 = WIDTH'(MOD - 64'd1);

   if (WIDTH < 1 || WIDTH > TFF_MAX_WIDTH) begin : g_bad_width
      $error("tff_bank: WIDTH must be in 1..32");
   end

   if (MOD < 64'd2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
      $error("tff_bank: MOD must be in 2..2**WIDTH");
   end

   logic [WIDTH-1:0] t_vec;
   logic             wrap_d;
   logic             wrap_q;

   // Next-toggle vector and wrap detection from mode, enable and current state.
   always_comb begin
      t_vec  = '0;
      wrap_d = 1'b0;
      if (en && !load) begin
         unique case (mode)
            TFF_MODE_TOGGLE: begin
               t_vec = t;
            end
            TFF_MODE_UP: begin
               // Out-of-range values above MOD-1 also wrap straight to zero.
               if (q >= MOD_M1) begin
                  t_vec  = q;
                  wrap_d = 1'b1;
               end else begin
                  t_vec = WIDTH'(tff_chain_up(TFF_MAX_WIDTH'(q)));
               end
            end
            TFF_MODE_DOWN: begin
               if (q == '0) begin
                  t_vec  = q ^ MOD_M1;
                  wrap_d = 1'b1;
               end else begin
                  t_vec = WIDTH'(tff_chain_down(TFF_MAX_WIDTH'(q)));
               end
            end
            TFF_MODE_HOLD: begin
               t_vec = '0;
            end
            default: begin
               t_vec = '0;
            end
         endcase
      end
   end

   // Terminal count depends only on state and mode, not on en.
   always_comb begin
      tc = 1'b0;
      unique case (mode)
         TFF_MODE_UP:   tc = (q == MOD_M1);
         TFF_MODE_DOWN: tc = (q == '0);
         default:       tc = 1'b0;
      endcase
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_cell #(
         .RESET_BIT (RESET_VAL[i])
      ) u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .t     (t_vec[i]),
         .load  (load),
         .d     (d[i]),
         .q     (q[i]),
         .qb    (qb[i])
      );
   end

   // Wrap pulse register: high for the one cycle following a wrap edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign wrap = wrap_q;

endmodule
